msi_snoop_controller: RTL and testbench
=======================================

# msi_snoop_controller

Parametrised, clocked snoop-side coherence controller for one private cache. It owns the per-line coherence state and tag array (MSI, optionally MESI) and accepts bus snoop requests over a valid/ready handshake. For each request it looks up the line, applies the protocol transition and sequences a blocking write-back of Modified data before issuing a one-cycle response. It sits between the snooping bus interface and the cache data array, and it also accepts local (processor-side) state updates.

## Interface
Parameters:
- NUM_LINES, 16, number of direct-mapped lines (power of two, ≥2)
- INDEX_W, $clog2(NUM_LINES), line index width
- TAG_W, 8, stored tag width
- MESI_EN, 0, 1 enables EXCLUSIVE state

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- snoop_valid  in  1  snoop request present
- snoop_ready  out  1  request accepted when valid&&ready
- snoop_op  in  2  01 READ_MISS, 10 WRITE_MISS, 11 INVALIDATE, 00 NOP
- snoop_index  in  INDEX_W  line index
- snoop_tag  in  TAG_W  address tag
- resp_valid  out  1  one-cycle response pulse (no backpressure)
- resp_hit  out  1  tag matched a valid line
- resp_abort  out  1  memory access must be aborted (this cache supplies data)
- resp_shared  out  1  line remains SHARED after the snoop
- resp_err  out  1  protocol violation (INVALIDATE hit a MODIFIED line)
- wb_valid  out  1  write-back request, held until wb_ready
- wb_ready  in  1  write-back accepted
- wb_index  out  INDEX_W  line to write back
- wb_tag  out  TAG_W  tag of line written back
- local_valid  in  1  local state/tag update request
- local_ready  out  1  local update accepted
- local_index  in  INDEX_W  line to update
- local_tag  in  TAG_W  new tag
- local_state  in  2  new state code

## Operation
- State codes: INVALID 00, MODIFIED 01, SHARED 10, EXCLUSIVE 11.
- FSM states are IDLE, LOOKUP, WRITEBACK and RESP.
- snoop_ready = (fsm==IDLE). local_ready = (fsm==IDLE) && !snoop_valid, so a snoop always wins over a local update.
- Snoop accept registers op, index and tag, then moves to LOOKUP.
- LOOKUP: hit = line state != INVALID && stored tag == captured tag. Transitions are applied only on a hit; a miss or NOP leaves the line unchanged and all flags 0.
  - MODIFIED + READ_MISS → SHARED, write-back, abort=1, shared=1.
  - MODIFIED + WRITE_MISS → INVALID, write-back, abort=1.
  - MODIFIED + INVALIDATE → unchanged, err=1, no write-back.
  - SHARED + READ_MISS → SHARED, shared=1. SHARED + WRITE_MISS or INVALIDATE → INVALID.
  - EXCLUSIVE + READ_MISS → SHARED, shared=1. EXCLUSIVE + WRITE_MISS or INVALIDATE → INVALID.
  - A write-back case goes to WRITEBACK. Every other case writes the new state at the end of LOOKUP and goes to RESP.
- WRITEBACK: wb_valid=1 with stable wb_index and wb_tag. On wb_valid&&wb_ready the new state is written and the FSM goes to RESP.
- RESP: resp_valid=1 with the flags for one cycle, then IDLE.
- Local update: accepted on local_valid&&local_ready; tag and state are written on the same edge. With MESI_EN=0, EXCLUSIVE is stored as SHARED.

## Timing
- Reset values: every line INVALID, every tag 0, FSM in IDLE. All resp_* and wb_* outputs are 0. snoop_ready=1 and local_ready=1 once rst_n deasserts (local_ready stays gated by snoop_valid).
- Snoop accepted at edge T: LOOKUP during T→T+1, resp_valid high in cycle T+2, snoop_ready high again at T+3.
- With a write-back: wb_valid rises in cycle T+2. If wb_ready is seen at edge W, resp_valid is high in cycle W+1 and snoop_ready at W+2. Minimum snoop-to-response time is 3 cycles.
- The array update and the response flags reflect the same transition. The stored state changes exactly at the LOOKUP exit edge (no write-back) or at the write-back handshake edge.
- Back-to-back snoops are serialised; there is no overlap.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous), the pending write-back is dropped and no response is issued.
- Indices wrap naturally modulo NUM_LINES; there is no bounds error.

## Structure
- Package msi_pkg holds the state codes, snoop op codes and FSM state enum.
- Sub-module msi_line_state_array holds the state and tag storage: one synchronous-write/combinational-read port shared by the FSM and the local path (they are mutually exclusive by construction), with asynchronous clear to INVALID.

## Test plan
- Reset, then a READ_MISS on line 3 → resp_valid at T+2 with hit=0 and all flags 0, and no wb_valid.
- Local write line 5 tag 0x2A MODIFIED, then READ_MISS to line 5 tag 0x2A → wb_valid with index 5 and tag 0x2A; hold wb_ready low 4 cycles; then abort=1, shared=1, and line 5 reads SHARED.
- Line 7 SHARED, tag 0x11: INVALIDATE with tag 0x11 → hit=1, line becomes INVALID; a repeat INVALIDATE → hit=0.
- snoop_valid and local_valid asserted together on line 2 → snoop accepted, local_ready=0 until IDLE, then the local update is applied.
- MESI_EN=1: line 1 EXCLUSIVE, READ_MISS → shared=1, abort=0, no write-back. MESI_EN=0: a local EXCLUSIVE write is stored as SHARED.
- rst_n pulsed low while wb_valid=1 → wb_valid drops immediately, no resp_valid, all lines INVALID.

Source files
------------

// File: rtl/msi_pkg.sv
// Shared types for the MSI/MESI snoop controller: line state codes, snoop ops,
// FSM states and the snoop transition table.
package msi_pkg;

   typedef enum logic [1:0] {
      ST_INVALID   = 2'b00,
      ST_MODIFIED  = 2'b01,
      ST_SHARED    = 2'b10,
      ST_EXCLUSIVE = 2'b11
   } line_state_e;

   typedef enum logic [1:0] {
      OP_NOP        = 2'b00,
      OP_READ_MISS  = 2'b01,
      OP_WRITE_MISS = 2'b10,
      OP_INVALIDATE = 2'b11
   } snoop_op_e;

   typedef enum logic [1:0] {
      FSM_IDLE      = 2'd0,
      FSM_LOOKUP    = 2'd1,
      FSM_WRITEBACK = 2'd2,
      FSM_RESP      = 2'd3
   } fsm_state_e;

   typedef struct packed {
      logic hit;
      logic abort;
      logic shared;
      logic err;
   } resp_flags_t;

   typedef struct packed {
      line_state_e next_state;
      logic        update;
      logic        writeback;
      resp_flags_t flags;
   } snoop_action_t;

   // A miss or NOP leaves the line alone and reports nothing at all.
   function automatic snoop_action_t snoop_action(input logic        hit,
                                                  input line_state_e cur,
                                                  input snoop_op_e   op);
      snoop_action_t a;
      a.next_state = cur;
      a.update     = 1'b0;
      a.writeback  = 1'b0;
      a.flags      = '0;
      if (hit && op != OP_NOP) begin
         a.flags.hit = 1'b1;
         a.update    = 1'b1;
         case (cur)
            ST_MODIFIED: begin
               case (op)
                  OP_READ_MISS: begin
                     a.next_state   = ST_SHARED;
                     a.writeback    = 1'b1;
                     a.flags.abort  = 1'b1;
                     a.flags.shared = 1'b1;
                  end
                  OP_WRITE_MISS: begin
                     a.next_state  = ST_INVALID;
                     a.writeback   = 1'b1;
                     a.flags.abort = 1'b1;
                  end
                  default: begin
                     a.update    = 1'b0;
                     a.flags.err = 1'b1;
                  end
               endcase
            end
            ST_SHARED, ST_EXCLUSIVE: begin
               if (op == OP_READ_MISS) begin
                  a.next_state   = ST_SHARED;
                  a.flags.shared = 1'b1;
               end else begin
                  a.next_state = ST_INVALID;
               end
            end
            default: a.update = 1'b0;
         endcase
      end
      return a;
   endfunction

endpackage

// File: rtl/msi_snoop_controller_if.sv
// Bus-side bundle of the snoop controller: snoop request/response, write-back
// handshake and the local (processor-side) update path.
interface msi_snoop_controller_if #(
   parameter int INDEX_W = 4,
   parameter int TAG_W   = 8
);
   logic               snoop_valid;
   logic               snoop_ready;
   logic [1:0]         snoop_op;
   logic [INDEX_W-1:0] snoop_index;
   logic [TAG_W-1:0]   snoop_tag;

   logic               resp_valid;
   logic               resp_hit;
   logic               resp_abort;
   logic               resp_shared;
   logic               resp_err;

   logic               wb_valid;
   logic               wb_ready;
   logic [INDEX_W-1:0] wb_index;
   logic [TAG_W-1:0]   wb_tag;

   logic               local_valid;
   logic               local_ready;
   logic [INDEX_W-1:0] local_index;
   logic [TAG_W-1:0]   local_tag;
   logic [1:0]         local_state;

   modport master (
      output snoop_valid, snoop_op, snoop_index, snoop_tag, wb_ready,
             local_valid, local_index, local_tag, local_state,
      input  snoop_ready, resp_valid, resp_hit, resp_abort, resp_shared,
             resp_err, wb_valid, wb_index, wb_tag, local_ready
   );

   modport slave (
      input  snoop_valid, snoop_op, snoop_index, snoop_tag, wb_ready,
             local_valid, local_index, local_tag, local_state,
      output snoop_ready, resp_valid, resp_hit, resp_abort, resp_shared,
             resp_err, wb_valid, wb_index, wb_tag, local_ready
   );
endinterface

// File: rtl/msi_line_state_array.sv
// Per-line coherence state and tag storage: one sync-write / comb-read port,
// asynchronously cleared to INVALID with zero tags.
module msi_line_state_array
   import msi_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int INDEX_W   = $clog2(NUM_LINES),
   parameter int TAG_W     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INDEX_W-1:0] index,
   output line_state_e        rd_state,
   output logic [TAG_W-1:0]   rd_tag,
   input  logic               we,
   input  line_state_e        wr_state,
   input  logic [TAG_W-1:0]   wr_tag
);

   line_state_e      state_q [NUM_LINES];
   line_state_e      state_d [NUM_LINES];
   logic [TAG_W-1:0] tag_q   [NUM_LINES];
   logic [TAG_W-1:0] tag_d   [NUM_LINES];

   assign rd_state = state_q[index];
   assign rd_tag   = tag_q[index];

   // NOTE: whole-array defaults first, so no path through this block leaves a
   // bit unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      if (we) begin
         state_d[index] = wr_state;
         tag_d[index]   = wr_tag;
      end
   end

   // NOTE: this storage is a flop array, not a RAM macro, so it takes the async
   // reset; every line must come up INVALID before the first snoop.
   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            state_q[i] <= ST_INVALID;
            tag_q[i]   <= '0;
         end
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
      end
   end

endmodule

// File: rtl/msi_snoop_controller.sv
// Snoop-side coherence controller: serialises bus snoops through
// IDLE -> LOOKUP -> (WRITEBACK) -> RESP and arbitrates local state updates.
module msi_snoop_controller
   import msi_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int INDEX_W   = $clog2(NUM_LINES),
   parameter int TAG_W     = 8,
   parameter int MESI_EN   = 0
) (
   input logic                   clk,
   input logic                   rst_n,
   msi_snoop_controller_if.slave bus
);

   fsm_state_e         fsm_q,   fsm_d;
   snoop_op_e          op_q,    op_d;
   logic [INDEX_W-1:0] index_q, index_d;
   logic [TAG_W-1:0]   tag_q,   tag_d;
   resp_flags_t        flags_q, flags_d;
   line_state_e        pend_q,  pend_d;

   logic [INDEX_W-1:0] arr_index;
   logic               arr_we;
   line_state_e        arr_wr_state;
   logic [TAG_W-1:0]   arr_wr_tag;
   line_state_e        rd_state;
   logic [TAG_W-1:0]   rd_tag;
   logic               hit;
   snoop_action_t      action;
   line_state_e        local_state_eff;

   msi_line_state_array #(
      .NUM_LINES (NUM_LINES),
      .INDEX_W   (INDEX_W),
      .TAG_W     (TAG_W)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .index    (arr_index),
      .rd_state (rd_state),
      .rd_tag   (rd_tag),
      .we       (arr_we),
      .wr_state (arr_wr_state),
      .wr_tag   (arr_wr_tag)
   );

   // Without MESI there is no EXCLUSIVE; a clean private line is just SHARED.
   always_comb begin
      local_state_eff = line_state_e'(bus.local_state);
      if (MESI_EN == 0 && local_state_eff == ST_EXCLUSIVE) begin
         local_state_eff = ST_SHARED;
      end
   end

   assign hit    = (rd_state != ST_INVALID) && (rd_tag == tag_q);
   assign action = snoop_action(hit, rd_state, op_q);

   always_comb begin
      fsm_d        = fsm_q;
      op_d         = op_q;
      index_d      = index_q;
      tag_d        = tag_q;
      flags_d      = flags_q;
      pend_d       = pend_q;
      arr_index    = index_q;
      arr_we       = 1'b0;
      arr_wr_state = pend_q;
      arr_wr_tag   = tag_q;
      case (fsm_q)
         FSM_IDLE: begin
            if (bus.snoop_valid) begin
               op_d    = snoop_op_e'(bus.snoop_op);
               index_d = bus.snoop_index;
               tag_d   = bus.snoop_tag;
               fsm_d   = FSM_LOOKUP;
            end else if (bus.local_valid) begin
               arr_index    = bus.local_index;
               arr_we       = 1'b1;
               arr_wr_state = local_state_eff;
               arr_wr_tag   = bus.local_tag;
            end
         end
         FSM_LOOKUP: begin
            flags_d = action.flags;
            pend_d  = action.next_state;
            if (action.writeback) begin
               fsm_d = FSM_WRITEBACK;
            end else begin
               arr_we       = action.update;
               arr_wr_state = action.next_state;
               fsm_d        = FSM_RESP;
            end
         end
         FSM_WRITEBACK: begin
            // The line only changes once the data has actually left the cache.
            if (bus.wb_ready) begin
               arr_we = 1'b1;
               fsm_d  = FSM_RESP;
            end
         end
         default: fsm_d = FSM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= FSM_IDLE;
         op_q    <= OP_NOP;
         index_q <= '0;
         tag_q   <= '0;
         flags_q <= '0;
         pend_q  <= ST_INVALID;
      end else begin
         fsm_q   <= fsm_d;
         op_q    <= op_d;
         index_q <= index_d;
         tag_q   <= tag_d;
         flags_q <= flags_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.snoop_ready = (fsm_q == FSM_IDLE);
   assign bus.local_ready = (fsm_q == FSM_IDLE) && !bus.snoop_valid;

   assign bus.resp_valid  = (fsm_q == FSM_RESP);
   assign bus.resp_hit    = bus.resp_valid && flags_q.hit;
   assign bus.resp_abort  = bus.resp_valid && flags_q.abort;
   assign bus.resp_shared = bus.resp_valid && flags_q.shared;
   assign bus.resp_err    = bus.resp_valid && flags_q.err;

   assign bus.wb_valid = (fsm_q == FSM_WRITEBACK);
   assign bus.wb_index = bus.wb_valid ? index_q : '0;
   assign bus.wb_tag   = bus.wb_valid ? tag_q   : '0;

endmodule

// File: tb/tb_msi_snoop_controller.sv
// Directed bench: an MSI instance and a MESI instance driven in lockstep, with
// hand-computed responses, write-back timing and stored line states.
module tb_msi_snoop_controller;
   import msi_pkg::*;

   localparam int NUM_LINES = 16;
   localparam int INDEX_W   = 4;
   localparam int TAG_W     = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic               snoop_valid, wb_ready, local_valid;
   logic [1:0]         snoop_op, local_state;
   logic [INDEX_W-1:0] snoop_index, local_index;
   logic [TAG_W-1:0]   snoop_tag, local_tag;

   int n_checks = 0;
   int n_fail   = 0;

   msi_snoop_controller_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus0 ();
   msi_snoop_controller_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus1 ();

   assign bus0.snoop_valid = snoop_valid;  assign bus1.snoop_valid = snoop_valid;
   assign bus0.snoop_op    = snoop_op;     assign bus1.snoop_op    = snoop_op;
   assign bus0.snoop_index = snoop_index;  assign bus1.snoop_index = snoop_index;
   assign bus0.snoop_tag   = snoop_tag;    assign bus1.snoop_tag   = snoop_tag;
   assign bus0.wb_ready    = wb_ready;     assign bus1.wb_ready    = wb_ready;
   assign bus0.local_valid = local_valid;  assign bus1.local_valid = local_valid;
   assign bus0.local_index = local_index;  assign bus1.local_index = local_index;
   assign bus0.local_tag   = local_tag;    assign bus1.local_tag   = local_tag;
   assign bus0.local_state = local_state;  assign bus1.local_state = local_state;

   msi_snoop_controller #(
      .NUM_LINES(NUM_LINES), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .MESI_EN(0)
   ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

   msi_snoop_controller #(
      .NUM_LINES(NUM_LINES), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .MESI_EN(1)
   ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_resp(input string name, input logic [3:0] exp_flags);
      check({name, "_resp_valid0"}, bus0.resp_valid, 1'b1);
      check({name, "_flags0"},
            {bus0.resp_hit, bus0.resp_abort, bus0.resp_shared, bus0.resp_err}, exp_flags);
      check({name, "_resp_valid1"}, bus1.resp_valid, 1'b1);
      check({name, "_flags1"},
            {bus1.resp_hit, bus1.resp_abort, bus1.resp_shared, bus1.resp_err}, exp_flags);
   endtask

   task automatic local_write(input logic [3:0] idx, input logic [7:0] tg, input logic [1:0] st);
      @(negedge clk);
      check("local_ready_idle", bus0.local_ready, 1'b1);
      local_valid = 1'b1;
      local_index = idx;
      local_tag   = tg;
      local_state = st;
      @(negedge clk);
      local_valid = 1'b0;
   endtask

   // Flags are {hit, abort, shared, err}; old_st is the line state expected to
   // survive unchanged while the write-back is stalled.
   task automatic do_snoop(input string name, input logic [1:0] op, input logic [3:0] idx,
                           input logic [7:0] tg, input logic exp_wb, input int stall,
                           input logic [1:0] old_st, input logic [3:0] exp_flags);
      @(negedge clk);
      check({name, "_snoop_ready"}, bus0.snoop_ready, 1'b1);
      snoop_valid = 1'b1;
      snoop_op    = op;
      snoop_index = idx;
      snoop_tag   = tg;
      @(negedge clk);
      snoop_valid = 1'b0;
      snoop_op    = 2'b00;
      check({name, "_lookup_no_resp"}, bus0.resp_valid, 1'b0);
      check({name, "_lookup_no_wb"}, bus0.wb_valid, 1'b0);
      @(negedge clk);
      if (exp_wb) begin
         check({name, "_wb_valid"}, bus0.wb_valid, 1'b1);
         check({name, "_wb_index"}, bus0.wb_index, idx);
         check({name, "_wb_tag"}, bus0.wb_tag, tg);
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({name, "_wb_held"}, bus0.wb_valid, 1'b1);
            check({name, "_wb_tag_stable"}, bus0.wb_tag, tg);
            check({name, "_stall_no_resp"}, bus0.resp_valid, 1'b0);
            check({name, "_state_before_wb"}, dut0.u_array.state_q[idx], old_st);
         end
         wb_ready = 1'b1;
         @(negedge clk);
         wb_ready = 1'b0;
         check({name, "_wb_dropped"}, bus0.wb_valid, 1'b0);
      end else begin
         check({name, "_no_wb"}, bus0.wb_valid, 1'b0);
      end
      check_resp(name, exp_flags);
      @(negedge clk);
      check({name, "_resp_pulse"}, bus0.resp_valid, 1'b0);
      check({name, "_ready_again"}, bus0.snoop_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n       = 1'b0;
      snoop_valid = 1'b0;  snoop_op    = 2'b00; snoop_index = '0; snoop_tag = '0;
      wb_ready    = 1'b0;  local_valid = 1'b0;  local_index = '0; local_tag = '0;
      local_state = 2'b00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_snoop_ready", bus0.snoop_ready, 1'b1);
      check("rst_local_ready", bus0.local_ready, 1'b1);
      check("rst_resp_valid", bus0.resp_valid, 1'b0);
      check("rst_wb_valid", bus0.wb_valid, 1'b0);
      for (int i = 0; i < NUM_LINES; i++) begin
         check("rst_line_invalid", dut0.u_array.state_q[i], ST_INVALID);
         check("rst_line_tag", dut0.u_array.tag_q[i], 8'h00);
      end

      // Miss on an empty cache.
      do_snoop("rm_miss_l3", OP_READ_MISS, 4'd3, 8'h33, 1'b0, 0, ST_INVALID, 4'b0000);

      // Modified line, read miss, write-back stalled four cycles.
      local_write(4'd5, 8'h2A, ST_MODIFIED);
      check("l5_modified", dut0.u_array.state_q[5], ST_MODIFIED);
      do_snoop("rm_mod_l5", OP_READ_MISS, 4'd5, 8'h2A, 1'b1, 4, ST_MODIFIED, 4'b1110);
      check("l5_shared", dut0.u_array.state_q[5], ST_SHARED);

      // Shared line: read keeps it shared, invalidate kills it, repeat misses.
      local_write(4'd7, 8'h11, ST_SHARED);
      do_snoop("rm_sh_l7", OP_READ_MISS, 4'd7, 8'h11, 1'b0, 0, ST_SHARED, 4'b1010);
      check("l7_still_shared", dut0.u_array.state_q[7], ST_SHARED);
      do_snoop("inv_sh_l7", OP_INVALIDATE, 4'd7, 8'h11, 1'b0, 0, ST_SHARED, 4'b1000);
      check("l7_invalid", dut0.u_array.state_q[7], ST_INVALID);
      do_snoop("inv_again_l7", OP_INVALIDATE, 4'd7, 8'h11, 1'b0, 0, ST_INVALID, 4'b0000);

      // Modified: write miss invalidates after write-back; invalidate is an error.
      local_write(4'd9, 8'h55, ST_MODIFIED);
      do_snoop("wm_mod_l9", OP_WRITE_MISS, 4'd9, 8'h55, 1'b1, 0, ST_MODIFIED, 4'b1100);
      check("l9_invalid", dut0.u_array.state_q[9], ST_INVALID);
      local_write(4'd10, 8'h66, ST_MODIFIED);
      do_snoop("inv_mod_l10", OP_INVALIDATE, 4'd10, 8'h66, 1'b0, 0, ST_MODIFIED, 4'b1001);
      check("l10_still_mod", dut0.u_array.state_q[10], ST_MODIFIED);
      do_snoop("rm_tagmiss_l10", OP_READ_MISS, 4'd10, 8'h67, 1'b0, 0, ST_MODIFIED, 4'b0000);
      do_snoop("nop_l10", OP_NOP, 4'd10, 8'h66, 1'b0, 0, ST_MODIFIED, 4'b0000);
      check("l10_nop_unchanged", dut0.u_array.state_q[10], ST_MODIFIED);

      // Snoop and local update on line 2 in the same cycle: snoop wins.
      @(negedge clk);
      snoop_valid = 1'b1; snoop_op = OP_READ_MISS; snoop_index = 4'd2; snoop_tag = 8'h22;
      local_valid = 1'b1; local_index = 4'd2; local_tag = 8'h22; local_state = ST_MODIFIED;
      #1;
      check("race_local_ready", bus0.local_ready, 1'b0);
      check("race_snoop_ready", bus0.snoop_ready, 1'b1);
      @(negedge clk);
      snoop_valid = 1'b0;
      check("race_lookup_local_ready", bus0.local_ready, 1'b0);
      @(negedge clk);
      check_resp("race_resp", 4'b0000);
      check("race_resp_local_ready", bus0.local_ready, 1'b0);
      @(negedge clk);
      check("race_idle_local_ready", bus0.local_ready, 1'b1);
      check("race_not_yet_written", dut0.u_array.state_q[2], ST_INVALID);
      @(negedge clk);
      local_valid = 1'b0;
      check("race_l2_state", dut0.u_array.state_q[2], ST_MODIFIED);
      check("race_l2_tag", dut0.u_array.tag_q[2], 8'h22);
      do_snoop("rm_mod_l2", OP_READ_MISS, 4'd2, 8'h22, 1'b1, 1, ST_MODIFIED, 4'b1110);

      // EXCLUSIVE: stored as SHARED without MESI, kept with MESI.
      local_write(4'd1, 8'h01, ST_EXCLUSIVE);
      check("msi_excl_as_shared", dut0.u_array.state_q[1], ST_SHARED);
      check("mesi_excl_kept", dut1.u_array.state_q[1], ST_EXCLUSIVE);
      do_snoop("rm_excl_l1", OP_READ_MISS, 4'd1, 8'h01, 1'b0, 0, ST_SHARED, 4'b1010);
      check("mesi_l1_shared", dut1.u_array.state_q[1], ST_SHARED);
      local_write(4'd4, 8'h44, ST_EXCLUSIVE);
      do_snoop("wm_excl_l4", OP_WRITE_MISS, 4'd4, 8'h44, 1'b0, 0, ST_SHARED, 4'b1000);
      check("mesi_l4_invalid", dut1.u_array.state_q[4], ST_INVALID);

      // Reset asserted while a write-back is pending.
      local_write(4'd6, 8'h77, ST_MODIFIED);
      @(negedge clk);
      snoop_valid = 1'b1; snoop_op = OP_READ_MISS; snoop_index = 4'd6; snoop_tag = 8'h77;
      @(negedge clk);
      snoop_valid = 1'b0;
      @(negedge clk);
      check("rstwb_wb_valid", bus0.wb_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rstwb_wb_drop0", bus0.wb_valid, 1'b0);
      check("rstwb_wb_drop1", bus1.wb_valid, 1'b0);
      check("rstwb_wb_tag", bus0.wb_tag, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rstwb_no_resp_in_rst", bus0.resp_valid, 1'b0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rstwb_no_resp_after", bus0.resp_valid, 1'b0);
         check("rstwb_no_wb_after", bus0.wb_valid, 1'b0);
      end
      check("rstwb_ready", bus0.snoop_ready, 1'b1);
      for (int i = 0; i < NUM_LINES; i++) begin
         check("rstwb_line_invalid", dut0.u_array.state_q[i], ST_INVALID);
      end
      do_snoop("rm_after_rst_l6", OP_READ_MISS, 4'd6, 8'h77, 1'b0, 0, ST_INVALID, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
